flash_op_scheduler: RTL
=======================

# flash_op_scheduler

Sequences complete SPI NOR flash operations (read, page program, sector erase) on top of the byte-level SPI engine, and shares that engine between two requesters with round-robin arbitration. It expands each request into the required command byte stream: write-enable prefix, command, 24-bit address, data, and status polling until the flash is ready. It then returns read data and completion status to the granted requester. It sits between the APB-side controller logic (requester 0), a boot/prefetch client (requester 1), and the shared SPI byte engine.

## Interface
- MAX_POLLS, 1024, status reads allowed per program/erase before timeout (≥1)
- POLL_GAP, 16, idle p_clk cycles between consecutive status reads (≥0)

- p_clk  input  1  clock, all logic on rising edge
- p_reset_n  input  1  reset; asynchronous, active-low
- req0, req1  input  1 each  request; held high until matching done pulse
- op0, op1  input  2 each  00 READ, 01 PROGRAM, 10 ERASE, 11 reserved
- addr0, addr1  input  24 each  flash byte address
- wdata0, wdata1  input  32 each  program data, sent MSB byte first
- done0, done1  output  1 each  one-cycle completion pulse
- rdata  output  32  read result, valid with done pulse; holds until next READ completes
- err  output  1  valid with done pulse: 1 = reserved op or poll timeout
- byte_req  output  1  byte transfer request to SPI engine
- byte_tx  output  8  byte to shift out
- byte_last  output  1  deassert chip select after this byte
- byte_ack  input  1  one-cycle: byte transferred
- byte_rx  input  8  byte shifted in, valid with byte_ack

## Operation
- States: IDLE, SEQ (stream bytes), GAP (poll spacing), POLL (status read), DONE.
- IDLE arbitration: round-robin. Pointer holds the last-granted index and resets to 1, so requester 0 wins first. With a single request, that request wins. With both asserted, the one not last granted wins. Inputs op/addr/wdata are latched at grant.
- Byte streams (byte_last on the marked byte "*"):
  - READ: 03, A[23:16], A[15:8], A[7:0], 00, 00, 00, 00*. The rx bytes of the final 4 fill rdata MSB first.
  - PROGRAM: 06*, then 02, A2, A1, A0, D[31:24], D[23:16], D[15:8], D[7:0]*, then POLL.
  - ERASE: 06*, then 20, A2, A1, A0*, then POLL.
  - Reserved op 11: no bytes; go straight to DONE with err=1.
- POLL: stream 05, 00*. The second ack's byte_rx[0] is WIP.
  - WIP=0 → DONE, err=0.
  - WIP=1 and poll count < MAX_POLLS → GAP for POLL_GAP cycles, then POLL again.
  - WIP=1 and count = MAX_POLLS → DONE, err=1.
- The poll counter clears at each grant and saturates (no wrap).
- DONE: pulse done for the granted requester for one cycle, update the rr pointer, return to IDLE.
- The byte engine is used only while a grant is active; there is never an interleave of requesters.

## Timing
- Reset values: byte_req=0, byte_tx=00, byte_last=0, done0=done1=0, rdata=0, err=0, state IDLE, rr pointer=1, counters 0.
- Reset is asynchronous: on assertion mid-operation, all outputs return to reset values immediately. A partial flash command is abandoned with no done pulse.
- Request seen in IDLE at edge N → byte_req=1 with the first byte from edge N+1 (reserved op: done at N+1).
- byte_req, byte_tx and byte_last are registered. They are held stable until the cycle byte_ack is sampled high. The next byte is presented on the following edge, or byte_req drops if the stream is finished.
- byte_ack sampled while byte_req=0 is ignored.
- Last ack of the operation at edge M → done pulse at M+1, with rdata/err valid the same cycle. IDLE is reached at M+2, so the earliest next grant is at M+2.
- GAP length is exactly POLL_GAP cycles of byte_req=0 between the final poll ack and the next poll's byte_req.
- A requester dropping req mid-operation does not abort the operation; done still pulses.

## Test plan
- READ from req0 with addr=0x123456 and the engine returning AA,BB,CC,DD on the last 4 acks → tx sequence 03,12,34,56,00×4. byte_last is set only on the 8th byte. done0 pulses with rdata=0xAABBCCDD and err=0.
- PROGRAM from req1 with wdata=0xCAFEF00D and WIP returning 1,1,0 → tx 06*, 02,addr,CA,FE,F0,0D*, then three 05,00* pairs spaced by POLL_GAP idle cycles. done1 pulses with err=0.
- ERASE with MAX_POLLS=4 and WIP stuck at 1 → exactly 4 polls, then done with err=1.
- req0 and req1 asserted together and held continuously → grants alternate 0,1,0,1. No byte of one operation is interleaved with the other.
- op=11 → done one cycle after grant with err=1 and byte_req never asserted.
- Assert p_reset_n low during the address bytes of a PROGRAM → byte_req=0 immediately, no done pulse. After release, a new req1 is granted first only if req0 is absent.

Source files
------------

// File: rtl/flash_op_scheduler.sv
// Two-requester SPI NOR operation sequencer: expands READ / PROGRAM / ERASE into
// byte streams for a shared SPI byte engine, with round-robin grant and WIP polling.
module flash_op_scheduler #(
  parameter int MAX_POLLS = 1024,
  parameter int POLL_GAP  = 16
) (
  input  logic        p_clk,
  input  logic        p_reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata,
  output logic        err,
  output logic        byte_req,
  output logic [7:0]  byte_tx,
  output logic        byte_last,
  input  logic        byte_ack,
  input  logic [7:0]  byte_rx
);

  localparam int PCW = $clog2(MAX_POLLS + 1);
  localparam int GCW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_PROG = 2'b01;
  localparam logic [1:0] OP_ERAS = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEQ  = 3'd1,
    S_GAP  = 3'd2,
    S_POLL = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic             gnt_q, gnt_d;
  logic [1:0]       op_q, op_d;
  logic [23:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       idx_q, idx_d;
  logic [PCW-1:0]   poll_cnt_q, poll_cnt_d;
  logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [23:0]      rx_sh_q, rx_sh_d;
  logic             byte_req_q, byte_req_d;
  logic [7:0]       byte_tx_q, byte_tx_d;
  logic             byte_last_q, byte_last_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             win_s;
  logic [1:0]       win_op_s;
  logic [23:0]      win_addr_s;
  logic [31:0]      win_wdata_s;
  logic             ack_s;
  logic             fin_s;
  logic             fin_gnt_s;
  logic [PCW-1:0]   poll_inc_s;

  // Byte idx of an op's main stream as {byte_last, byte}; status polls are handled separately.
  function automatic logic [8:0] seq_byte(input logic [1:0] op, input logic [3:0] idx,
                                          input logic [23:0] a, input logic [31:0] d);
    logic [8:0] r;
    r = 9'h000;
    case (op)
      OP_READ: begin
        case (idx)
          4'd0:    r = {1'b0, 8'h03};
          4'd1:    r = {1'b0, a[23:16]};
          4'd2:    r = {1'b0, a[15:8]};
          4'd3:    r = {1'b0, a[7:0]};
          4'd7:    r = {1'b1, 8'h00};
          default: r = {1'b0, 8'h00};
        endcase
      end
      OP_PROG: begin
        case (idx)
          4'd0:    r = {1'b1, 8'h06};
          4'd1:    r = {1'b0, 8'h02};
          4'd2:    r = {1'b0, a[23:16]};
          4'd3:    r = {1'b0, a[15:8]};
          4'd4:    r = {1'b0, a[7:0]};
          4'd5:    r = {1'b0, d[31:24]};
          4'd6:    r = {1'b0, d[23:16]};
          4'd7:    r = {1'b0, d[15:8]};
          4'd8:    r = {1'b1, d[7:0]};
          default: r = 9'h000;
        endcase
      end
      OP_ERAS: begin
        case (idx)
          4'd0:    r = {1'b1, 8'h06};
          4'd1:    r = {1'b0, 8'h20};
          4'd2:    r = {1'b0, a[23:16]};
          4'd3:    r = {1'b0, a[15:8]};
          4'd4:    r = {1'b1, a[7:0]};
          default: r = 9'h000;
        endcase
      end
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] last_idx(input logic [1:0] op);
    logic [3:0] r;
    case (op)
      OP_READ: r = 4'd7;
      OP_PROG: r = 4'd8;
      OP_ERAS: r = 4'd4;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    poll_cnt_d  = poll_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    rx_sh_d     = rx_sh_q;
    byte_req_d  = byte_req_q;
    byte_tx_d   = byte_tx_q;
    byte_last_d = byte_last_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    fin_s       = 1'b0;
    fin_gnt_s   = gnt_q;
    ack_s       = byte_req_q & byte_ack;

    // rr_q is the last-granted index, so on contention the other side wins.
    if (req0 && req1) begin
      win_s = ~rr_q;
    end else if (req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    win_op_s    = win_s ? op1    : op0;
    win_addr_s  = win_s ? addr1  : addr0;
    win_wdata_s = win_s ? wdata1 : wdata0;
    poll_inc_s  = (poll_cnt_q == PCW'(MAX_POLLS)) ? poll_cnt_q : poll_cnt_q + PCW'(1);

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt_d      = win_s;
          op_d       = win_op_s;
          addr_d     = win_addr_s;
          wdata_d    = win_wdata_s;
          poll_cnt_d = PCW'(0);
          idx_d      = 4'd0;
          if (win_op_s == OP_RSV) begin
            state_d   = S_DONE;
            err_d     = 1'b1;
            fin_s     = 1'b1;
            fin_gnt_s = win_s;
          end else begin
            state_d                  = S_SEQ;
            byte_req_d               = 1'b1;
            {byte_last_d, byte_tx_d} = seq_byte(win_op_s, 4'd0, win_addr_s, win_wdata_s);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEQ: begin
        if (ack_s) begin
          rx_sh_d = {rx_sh_q[15:0], byte_rx};
          if (idx_q == last_idx(op_q)) begin
            if (op_q == OP_READ) begin
              state_d     = S_DONE;
              byte_req_d  = 1'b0;
              byte_tx_d   = 8'h00;
              byte_last_d = 1'b0;
              rdata_d     = {rx_sh_q, byte_rx};
              err_d       = 1'b0;
              fin_s       = 1'b1;
            end else begin
              state_d     = S_POLL;
              idx_d       = 4'd0;
              byte_tx_d   = CMD_RDSR;
              byte_last_d = 1'b0;
            end
          end else begin
            idx_d                    = idx_q + 4'd1;
            {byte_last_d, byte_tx_d} = seq_byte(op_q, idx_q + 4'd1, addr_q, wdata_q);
          end
        end else begin
          state_d = S_SEQ;
        end
      end
      S_POLL: begin
        if (ack_s) begin
          if (idx_q == 4'd0) begin
            idx_d       = 4'd1;
            byte_tx_d   = 8'h00;
            byte_last_d = 1'b1;
          end else begin
            poll_cnt_d  = poll_inc_s;
            byte_req_d  = 1'b0;
            byte_tx_d   = 8'h00;
            byte_last_d = 1'b0;
            if (!byte_rx[0]) begin
              state_d = S_DONE;
              err_d   = 1'b0;
              fin_s   = 1'b1;
            end else if (poll_inc_s >= PCW'(MAX_POLLS)) begin
              state_d = S_DONE;
              err_d   = 1'b1;
              fin_s   = 1'b1;
            end else if (POLL_GAP == 0) begin
              state_d    = S_POLL;
              idx_d      = 4'd0;
              byte_req_d = 1'b1;
              byte_tx_d  = CMD_RDSR;
            end else begin
              state_d   = S_GAP;
              gap_cnt_d = GCW'(POLL_GAP - 1);
            end
          end
        end else begin
          state_d = S_POLL;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GCW'(0)) begin
          state_d     = S_POLL;
          idx_d       = 4'd0;
          byte_req_d  = 1'b1;
          byte_tx_d   = CMD_RDSR;
          byte_last_d = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q - GCW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        rr_d    = gnt_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done0_d = fin_s & ~fin_gnt_s;
    done1_d = fin_s & fin_gnt_s;
  end

  // State and output registers; rr pointer resets to 1 so requester 0 wins first.
  always_ff @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b1;
      gnt_q       <= 1'b0;
      op_q        <= 2'b00;
      addr_q      <= 24'h000000;
      wdata_q     <= 32'h00000000;
      idx_q       <= 4'd0;
      poll_cnt_q  <= PCW'(0);
      gap_cnt_q   <= GCW'(0);
      rx_sh_q     <= 24'h000000;
      byte_req_q  <= 1'b0;
      byte_tx_q   <= 8'h00;
      byte_last_q <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata_q     <= 32'h00000000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      poll_cnt_q  <= poll_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rx_sh_q     <= rx_sh_d;
      byte_req_q  <= byte_req_d;
      byte_tx_q   <= byte_tx_d;
      byte_last_q <= byte_last_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign byte_req  = byte_req_q;
  assign byte_tx   = byte_tx_q;
  assign byte_last = byte_last_q;

endmodule
